// File: rtl/pwm_bank_if.sv
// Byte-wide register bus between the SPI register front-end (master) and a peripheral (slave).
// The master issues 1-cycle write or read strobes. The slave answers each read one cycle later with rd_valid.
interface pwm_bank_if;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/pwm_bank_peripheral.sv
// Bank of NUM_CH PWM outputs that share one prescaled counter. Each channel has its own duty register.
// Duty updates can be double-buffered so that new values take effect at period boundaries.
module pwm_bank_peripheral #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_bank_if.slave         bus,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam logic [6:0]       A_PRESC  = 7'h10;
  localparam logic [6:0]       A_CTRL   = 7'h11;
  // The counter runs over 0..MAX-1, with MAX = 2^CNT_W-1. A duty of MAX therefore keeps the output high.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CNT_W) - 2);

  logic [NUM_CH-1:0]  r_out_en;
  logic [NUM_CH-1:0]  r_pwm_en;
  logic [PRESC_W-1:0] r_presc;
  logic               r_run;
  logic               r_shadow;
  logic [CNT_W-1:0]   r_duty_pend [NUM_CH];
  logic [CNT_W-1:0]   r_duty_act  [NUM_CH];
  logic [PRESC_W-1:0] r_pcnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]  r_out;
  logic               r_period_start;
  logic [7:0]         r_rd_data;
  logic               r_rd_valid;

  logic               w_tick;
  logic               w_wrap;
  logic               w_presc_wr;
  logic               w_ctrl_wr;
  logic               w_shadow_clr;
  logic [CNT_W-1:0]   w_wr_duty;
  logic [NUM_CH-1:0]  w_duty_wr;
  logic [7:0]         w_rd_data;

  always_comb begin
    // NOTE: every signal assigned here gets a default value first, so no path can leave one unassigned and infer a latch.
    w_duty_wr    = '0;
    w_tick       = r_run && (r_pcnt == r_presc);
    w_wrap       = w_tick && (r_cnt == CNT_LAST);
    w_presc_wr   = bus.wr_en && (bus.wr_addr == A_PRESC);
    w_ctrl_wr    = bus.wr_en && (bus.wr_addr == A_CTRL);
    w_shadow_clr = w_ctrl_wr && r_shadow && !bus.wr_data[0];
    w_wr_duty    = bus.wr_data[CNT_W-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      w_duty_wr[c] = bus.wr_en && (bus.wr_addr == 7'(64 + c));
    end
  end

  // Enable bits, prescaler setting and control register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_en <= '0;
      r_pwm_en <= '0;
      r_presc  <= '0;
      r_run    <= 1'b1;
      r_shadow <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with <= only, so every flop samples the values from before this edge.
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.wr_en && (bus.wr_addr == 7'(c / 8)))
          r_out_en[c] <= bus.wr_data[3'(c % 8)];
        if (bus.wr_en && (bus.wr_addr == 7'(8 + c / 8)))
          r_pwm_en[c] <= bus.wr_data[3'(c % 8)];
      end
      if (w_presc_wr) r_presc <= bus.wr_data[PRESC_W-1:0];
      if (w_ctrl_wr) begin
        r_run    <= bus.wr_data[1];
        r_shadow <= bus.wr_data[0];
      end
    end
  end

  // Prescaler and shared period counter. A write to PRESC restarts only the prescaler count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt         <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_wrap;
      if (!r_run) begin
        r_pcnt <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_presc_wr || w_tick) r_pcnt <= '0;
        else                      r_pcnt <= r_pcnt + 1'b1;
        if (w_tick) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
    end
  end

  // Duty registers. The active copy loads at the wrap, or when shadowing is switched off.
  // A duty write in that same cycle bypasses straight into the active copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the duty arrays are small flop banks, not RAM, so they are reset like all other state.
      for (int c = 0; c < NUM_CH; c++) begin
        r_duty_pend[c] <= '0;
        r_duty_act[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_duty_wr[c]) r_duty_pend[c] <= w_wr_duty;
        if (w_duty_wr[c] && !r_shadow)
          r_duty_act[c] <= w_wr_duty;
        else if (r_shadow && (w_wrap || w_shadow_clr))
          r_duty_act[c] <= w_duty_wr[c] ? w_wr_duty : r_duty_pend[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_out[c] <= r_out_en[c] & (!r_pwm_en[c] | (r_cnt < r_duty_act[c]));
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rd_addr == 7'(c / 8))      w_rd_data[3'(c % 8)] = r_out_en[c];
      if (bus.rd_addr == 7'(8 + c / 8))  w_rd_data[3'(c % 8)] = r_pwm_en[c];
      if (bus.rd_addr == 7'(64 + c))     w_rd_data[CNT_W-1:0] = r_duty_pend[c];
    end
    if (bus.rd_addr == A_PRESC) w_rd_data[PRESC_W-1:0] = r_presc;
    if (bus.rd_addr == A_CTRL)  w_rd_data[1:0]         = {r_run, r_shadow};
  end

  // The read data is captured from pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= w_rd_data;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign out          = r_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_bank_peripheral.sv
// Directed self-checking bench for pwm_bank_peripheral with the default parameters (16 channels, 8-bit counter).
// Inputs are driven and outputs are sampled 1 ns after each rising clock edge.
module tb_pwm_bank_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] out;
  logic        period_start;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  pwm_bank_if bus ();

  pwm_bank_peripheral #(.NUM_CH(16), .CNT_W(8), .PRESC_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [7:0] d, output logic v);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en   = 1'b0;
    v = bus.rd_valid;
    d = bus.rd_data;
  endtask

  // Advances to the next sample at which period_start is high. If none arrives within the budget, one failure is recorded.
  task automatic wait_ps();
    int n;
    n = 0;
    tick();
    while (period_start !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_period_start: no pulse within %0d cycles", n);
    end
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    repeat (n) begin
      tick();
      if (out[0] === 1'b1) h++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       v;
    int         n;
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: out=%h ps=%b rv=%b rd=%h, required 0/0/0/0",
               out, period_start, bus.rd_valid, bus.rd_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    bus_read(7'h11, d, v);
    checks++;
    if (v !== 1'b1 || d !== 8'h02) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b data=%h, required 1/02", v, d);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_pulse: valid=%b, required 0", bus.rd_valid);
    end
    wait_ps();
    n = 0;
    do begin
      tick();
      n++;
    end while (period_start !== 1'b1 && n < 600);
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL period_interval: %0d clk, required 255", n);
    end
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL idle_out: out=%h, required 0000", out);
    end
  endtask

  task automatic test_static_high();
    int bad;
    bus_write(7'h00, 8'h01);
    tick();
    bad = 0;
    repeat (300) begin
      tick();
      if (out !== 16'h0001) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL static_high: %0d cycles with out!=0001, required 0", bad);
    end
  endtask

  task automatic test_pwm_half();
    int h;
    bus_write(7'h08, 8'h01);
    bus_write(7'h40, 8'h80);
    wait_ps();
    count_high(255, h);
    checks++;
    if (h != 128) begin
      errors++;
      $display("FAIL pwm_half: high=%0d of 255, required 128", h);
    end
    checks++;
    if (out[15:1] !== 15'h0) begin
      errors++;
      $display("FAIL other_channels: out[15:1]=%h, required 0", out[15:1]);
    end
  endtask

  task automatic test_presc();
    int h;
    bus_write(7'h10, 8'h03);
    wait_ps();
    count_high(1020, h);
    checks++;
    if (h != 512) begin
      errors++;
      $display("FAIL presc3: high=%0d of 1020, required 512", h);
    end
  endtask

  task automatic test_duty_extremes();
    int h;
    bus_write(7'h40, 8'hFF);
    wait_ps();
    count_high(1020, h);
    checks++;
    if (h != 1020) begin
      errors++;
      $display("FAIL duty_max: high=%0d of 1020, required 1020", h);
    end
    bus_write(7'h40, 8'h00);
    wait_ps();
    count_high(1020, h);
    checks++;
    if (h != 0) begin
      errors++;
      $display("FAIL duty_zero: high=%0d of 1020, required 0", h);
    end
    bus_write(7'h10, 8'h00);
    bus_write(7'h40, 8'h80);
  endtask

  task automatic test_shadow();
    logic [7:0] d;
    logic       v;
    int         h;
    int         c0;
    bus_write(7'h11, 8'h03);
    wait_ps();
    c0 = cyc;
    bus_write(7'h40, 8'h40);
    bus_read(7'h40, d, v);
    checks++;
    if (v !== 1'b1 || d !== 8'h40) begin
      errors++;
      $display("FAIL shadow_readback: valid=%b data=%h, required 1/40", v, d);
    end
    while (cyc < c0 + 100) tick();
    checks++;
    if (out[0] !== 1'b1) begin
      errors++;
      $display("FAIL shadow_hold: out0=%b at count 99, required 1", out[0]);
    end
    wait_ps();
    count_high(255, h);
    checks++;
    if (h != 64) begin
      errors++;
      $display("FAIL shadow_load: high=%0d of 255, required 64", h);
    end
    bus_write(7'h40, 8'hC0);
    bus_write(7'h11, 8'h02);
    wait_ps();
    count_high(255, h);
    checks++;
    if (h != 192) begin
      errors++;
      $display("FAIL shadow_clear_copy: high=%0d of 255, required 192", h);
    end
  endtask

  task automatic test_rd_wr_same();
    logic [7:0] d;
    logic       v;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 7'h10;
    bus.wr_data = 8'h05;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 7'h10;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rd_wr_same: valid=%b data=%h, required 1/00", bus.rd_valid, bus.rd_data);
    end
    bus_read(7'h10, d, v);
    checks++;
    if (d !== 8'h05) begin
      errors++;
      $display("FAIL rd_after_wr: data=%h, required 05", d);
    end
    bus_write(7'h10, 8'h00);
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    logic       v;
    bus_write(7'h20, 8'hFF);
    bus_read(7'h20, d, v);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL unmapped_20: data=%h, required 00", d);
    end
    bus_write(7'h50, 8'hAA);
    bus_read(7'h50, d, v);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL duty_beyond_ch: data=%h, required 00", d);
    end
    bus_read(7'h08, d, v);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL pwm_en_read: data=%h, required 01", d);
    end
    bus_write(7'h11, 8'hFF);
    bus_read(7'h11, d, v);
    checks++;
    if (d !== 8'h03) begin
      errors++;
      $display("FAIL ctrl_bits: data=%h, required 03", d);
    end
    bus_write(7'h11, 8'h02);
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    logic       v;
    bus_write(7'h08, 8'h00);
    tick();
    tick();
    checks++;
    if (out[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_out: out0=%b, required 1", out[0]);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_out: out=%h ps=%b, required 0000/0", out, period_start);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    bus_read(7'h00, d, v);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_en: data=%h, required 00", d);
    end
    bus_read(7'h40, d, v);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_duty0: data=%h, required 00", d);
    end
    bus_read(7'h11, d, v);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL reset_ctrl_again: data=%h, required 02", d);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_static_high();
    test_pwm_half();
    test_presc();
    test_duty_extremes();
    test_shadow();
    test_rd_wr_same();
    test_unmapped();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
